dual_wb_writer: RTL and testbench
=================================

// Module: dual_wb_writer
// PURPOSE
// Writeback-side driver for the dual-issue 32x32 register file write ports.
// - Takes up to two retiring results per cycle (lane 1 older, lane 2 younger).
// - Normalises each pair: drops r0 writes and resolves same-destination collisions.
// - Queues pairs while the register file is held, and drives we/writeaddr/writedata
//   for both ports in program order.
// - Exports a per-register pending vector so issue logic can stall dependent reads.
// PARAMETERS
// DEPTH  4   pair-entries in queue; power of 2, >=2
// NREG   32  architectural registers; pending vector width
// PORTS
// clk          in   1      clock
// rst          in   1      reset, asynchronous, active-high
// in_valid_1   in   1      lane 1 (older) result valid
// in_addr_1    in   5      lane 1 destination register
// in_data_1    in   32     lane 1 result
// in_valid_2   in   1      lane 2 (younger) result valid
// in_addr_2    in   5      lane 2 destination register
// in_data_2    in   32     lane 2 result
// in_ready     out  1      pair accepted at edge when in_ready=1; equals !full
// hold         in   1      1 = issue no new writes next cycle
// we_1         out  1      regfile port 1 write enable (registered)
// writeaddr_1  out  5      regfile port 1 address (registered)
// writedata_1  out  32     regfile port 1 data (registered)
// we_2/writeaddr_2/writedata_2  out 1/5/32  regfile port 2, same rules
// pending      out  NREG   bit r=1 while a write to r is queued or on the ports
// count        out  clog2(DEPTH)+1  queued pair-entries, excluding output regs
// BEHAVIOUR
// - Reset (async): queue emptied; we_*=0; writeaddr_*=0; writedata_*=0;
//   pending=0; count=0; in_ready=1. Reset mid-operation discards all queued writes.
// - Accept: a pair is accepted at a rising edge when in_ready=1 and either
//   in_valid is 1. When in_ready=0, inputs are ignored; the upstream holds them.
// - Normalise on accept:
//   - a lane with addr==0 is invalidated;
//   - both lanes valid with equal addr: lane 1 is invalidated (younger wins);
//   - a pair that has no valid lane after normalising is accepted, not stored.
// - Issue: at each edge with hold=0, output regs load the oldest pair:
//   - from the queue head if count>0 (pop);
//   - else from the pair accepted at that edge (bypass, latency 1 cycle);
//   - else with we_*=0.
//   Lane 1 -> port 1, lane 2 -> port 2. Ports with we=0 keep their last addr/data.
// - Hold: at an edge with hold=1, output regs load we_*=0 and nothing is popped.
//   An accepted pair is enqueued. The write already on the ports completes at that edge.
// - Queue: circular buffer with wrapping rd/wr pointers. full = (count==DEPTH).
//   - in_ready is derived from registered count, so a full queue blocks push even
//     when a pop happens in the same cycle.
//   - push+pop in one cycle: count unchanged.
//   - Pairs always leave in acceptance order. A queued pair is never merged with a
//     newer pair.
// - Pending: combinational OR over valid lanes of queued entries and we_* ports.
//   pending[0] is always 0.
// - Width: count ranges 0..DEPTH. Pointers are clog2(DEPTH) bits and wrap naturally.
// TESTING
// - Reset: rst pulse mid-burst (count=3) -> next cycle count=0, we_*=0, pending=0,
//   in_ready=1.
// - Bypass: hold=0, empty; lane1 r5=0x11, lane2 r6=0x22 -> next cycle we_1=1 addr5
//   0x11, we_2=1 addr6 0x22; pending bits 5,6 set for 1 cycle.
// - Collision/r0: lane1 r7=0xA, lane2 r7=0xB -> only we_2 r7=0xB.
//   lane1 r0=0x1, lane2 r0=0x2 -> no write, count unchanged.
// - Hold/full: hold=1, push 5 pairs r1..r5 with DEPTH=4 -> in_ready=0 after 4th,
//   count=4, pending bits 1..4 set; 5th held upstream.
// - Drain order: release hold -> writes r1,r2,r3,r4 on successive cycles, then r5
//   after its acceptance; count drops 4..0; no reordering.
// - Wrap/concurrent: with hold=0, sustain push+pop for 2*DEPTH cycles -> count
//   constant, data matches input sequence across pointer wrap.

Source files
------------

// File: rtl/dual_wb_writer.sv
// dual_wb_writer: writeback driver for the two register-file write ports.
// Normalises each retiring pair, queues pairs while the register file is held,
// and publishes a per-register pending mask for issue-side hazard stalls.
module dual_wb_writer #(
  parameter int DEPTH = 4,
  parameter int NREG  = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid_1,
  input  logic [4:0]                 in_addr_1,
  input  logic [31:0]                in_data_1,
  input  logic                       in_valid_2,
  input  logic [4:0]                 in_addr_2,
  input  logic [31:0]                in_data_2,
  output logic                       in_ready,
  input  logic                       hold,
  output logic                       we_1,
  output logic [4:0]                 writeaddr_1,
  output logic [31:0]                writedata_1,
  output logic                       we_2,
  output logic [4:0]                 writeaddr_2,
  output logic [31:0]                writedata_2,
  output logic [NREG-1:0]            pending,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic        v1;
    logic [4:0]  a1;
    logic [31:0] d1;
    logic        v2;
    logic [4:0]  a2;
    logic [31:0] d2;
  } pair_t;

  pair_t          mem_q [DEPTH];
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]  count_q, count_d;
  logic           we_1_q, we_1_d, we_2_q, we_2_d;
  logic [4:0]     addr_1_q, addr_1_d, addr_2_q, addr_2_d;
  logic [31:0]    data_1_q, data_1_d, data_2_q, data_2_d;

  pair_t          acc_pair, iss_pair, head;
  logic           accept, store, empty, pop, push, bypass;
  logic [NREG-1:0] pending_c;

  assign in_ready = (count_q != CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign head     = mem_q[rd_ptr_q];

  // Normalise the incoming pair: drop r0 targets, younger lane wins a collision.
  always_comb begin
    acc_pair    = '0;
    acc_pair.v1 = in_valid_1 && (in_addr_1 != 5'd0);
    acc_pair.a1 = in_addr_1;
    acc_pair.d1 = in_data_1;
    acc_pair.v2 = in_valid_2 && (in_addr_2 != 5'd0);
    acc_pair.a2 = in_addr_2;
    acc_pair.d2 = in_data_2;
    if (acc_pair.v1 && acc_pair.v2 && (in_addr_1 == in_addr_2))
      acc_pair.v1 = 1'b0;
  end

  // Queue control: bypass only when nothing older is waiting, so order is kept.
  always_comb begin
    accept   = in_ready && (in_valid_1 || in_valid_2);
    store    = accept && (acc_pair.v1 || acc_pair.v2);
    pop      = !hold && !empty;
    bypass   = !hold && empty && store;
    push     = store && !bypass;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    count_d  = count_q;
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (!push && pop) count_d = count_q - CW'(1);
  end

  // Select the pair to issue and compute next port state; idle ports keep addr/data.
  always_comb begin
    iss_pair = '0;
    if (pop)         iss_pair = head;
    else if (bypass) iss_pair = acc_pair;
    we_1_d   = iss_pair.v1;
    we_2_d   = iss_pair.v2;
    addr_1_d = iss_pair.v1 ? iss_pair.a1 : addr_1_q;
    data_1_d = iss_pair.v1 ? iss_pair.d1 : data_1_q;
    addr_2_d = iss_pair.v2 ? iss_pair.a2 : addr_2_q;
    data_2_d = iss_pair.v2 ? iss_pair.d2 : data_2_q;
  end

  // Pending mask: every valid lane of occupied queue slots plus the live ports.
  always_comb begin
    pair_t         e;
    logic [AW-1:0] slot;
    pending_c = '0;
    for (int k = 0; k < DEPTH; k++) begin
      slot = rd_ptr_q + AW'(k);
      e    = mem_q[slot];
      if (CW'(k) < count_q) begin
        if (e.v1) pending_c[e.a1] = 1'b1;
        if (e.v2) pending_c[e.a2] = 1'b1;
      end
    end
    if (we_1_q) pending_c[addr_1_q] = 1'b1;
    if (we_2_q) pending_c[addr_2_q] = 1'b1;
    pending_c[0] = 1'b0;
  end

  // Queue storage; contents are don't-care outside the occupied window.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= acc_pair;
  end

  // Pointers, occupancy and registered port outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      we_1_q   <= 1'b0;
      we_2_q   <= 1'b0;
      addr_1_q <= '0;
      addr_2_q <= '0;
      data_1_q <= '0;
      data_2_q <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      we_1_q   <= we_1_d;
      we_2_q   <= we_2_d;
      addr_1_q <= addr_1_d;
      addr_2_q <= addr_2_d;
      data_1_q <= data_1_d;
      data_2_q <= data_2_d;
    end
  end

  assign we_1        = we_1_q;
  assign we_2        = we_2_q;
  assign writeaddr_1 = addr_1_q;
  assign writeaddr_2 = addr_2_q;
  assign writedata_1 = data_1_q;
  assign writedata_2 = data_2_q;
  assign pending     = pending_c;
  assign count       = count_q;

endmodule

// File: tb/tb_dual_wb_writer.sv
// Directed bench for dual_wb_writer: reset, bypass, normalisation, hold/full,
// drain order and pointer wrap under sustained push+pop.
module tb_dual_wb_writer;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid_1, in_valid_2, hold;
  logic [4:0]  in_addr_1, in_addr_2;
  logic [31:0] in_data_1, in_data_2;
  logic        in_ready, we_1, we_2;
  logic [4:0]  writeaddr_1, writeaddr_2;
  logic [31:0] writedata_1, writedata_2;
  logic [31:0] pending;
  logic [2:0]  count;

  int n_tests = 0;
  int n_fail  = 0;

  dual_wb_writer #(.DEPTH(4), .NREG(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid_1(in_valid_1), .in_addr_1(in_addr_1), .in_data_1(in_data_1),
    .in_valid_2(in_valid_2), .in_addr_2(in_addr_2), .in_data_2(in_data_2),
    .in_ready(in_ready), .hold(hold),
    .we_1(we_1), .writeaddr_1(writeaddr_1), .writedata_1(writedata_1),
    .we_2(we_2), .writeaddr_2(writeaddr_2), .writedata_2(writedata_2),
    .pending(pending), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        hold, v1, v2;
    logic [4:0]  a1, a2;
    logic [31:0] d1, d2;
    logic        e_we1, e_we2;
    logic [4:0]  e_a1, e_a2;
    logic [31:0] e_d1, e_d2;
    logic [2:0]  e_cnt;
    logic        e_rdy;
    logic [31:0] e_pend;
  } vec_t;

  vec_t tbl [16];

  function automatic vec_t mk(
    input logic h, input logic v1, input logic [4:0] a1, input logic [31:0] d1,
    input logic v2, input logic [4:0] a2, input logic [31:0] d2,
    input logic ew1, input logic [4:0] ea1, input logic [31:0] ed1,
    input logic ew2, input logic [4:0] ea2, input logic [31:0] ed2,
    input logic [2:0] ec, input logic er, input logic [31:0] ep);
    vec_t v;
    v.hold = h; v.v1 = v1; v.a1 = a1; v.d1 = d1; v.v2 = v2; v.a2 = a2; v.d2 = d2;
    v.e_we1 = ew1; v.e_a1 = ea1; v.e_d1 = ed1;
    v.e_we2 = ew2; v.e_a2 = ea2; v.e_d2 = ed2;
    v.e_cnt = ec; v.e_rdy = er; v.e_pend = ep;
    return v;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic h, input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                       input logic v2, input logic [4:0] a2, input logic [31:0] d2);
    @(negedge clk);
    hold = h; in_valid_1 = v1; in_addr_1 = a1; in_data_1 = d1;
    in_valid_2 = v2; in_addr_2 = a2; in_data_2 = d2;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    hold = 1'b0; in_valid_1 = 1'b0; in_valid_2 = 1'b0;
    in_addr_1 = '0; in_addr_2 = '0; in_data_1 = '0; in_data_2 = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [31:0] wd1 [9];
  logic [4:0]  wa1 [9];
  logic [31:0] wd2 [9];
  logic [4:0]  wa2 [9];

  initial begin
    rst = 1'b1;
    hold = 1'b0; in_valid_1 = 1'b0; in_valid_2 = 1'b0;
    in_addr_1 = '0; in_addr_2 = '0; in_data_1 = '0; in_data_2 = '0;

    // bypass, normalisation, hold/full, drain order
    tbl[0]  = mk(0,1,5,32'h11,1,6,32'h22,    1,5,32'h11,1,6,32'h22,     0,1,32'h60);
    tbl[1]  = mk(0,0,0,0,0,0,0,              0,5,32'h11,0,6,32'h22,     0,1,32'h0);
    tbl[2]  = mk(0,1,7,32'hA,1,7,32'hB,      0,5,32'h11,1,7,32'hB,      0,1,32'h80);
    tbl[3]  = mk(0,1,0,32'h1,1,0,32'h2,      0,5,32'h11,0,7,32'hB,      0,1,32'h0);
    tbl[4]  = mk(0,1,0,32'h3,1,9,32'h99,     0,5,32'h11,1,9,32'h99,     0,1,32'h200);
    tbl[5]  = mk(1,1,1,32'h101,0,0,0,        0,5,32'h11,0,9,32'h99,     1,1,32'h2);
    tbl[6]  = mk(1,1,2,32'h102,1,10,32'h20A, 0,5,32'h11,0,9,32'h99,     2,1,32'h406);
    tbl[7]  = mk(1,1,3,32'h103,0,0,0,        0,5,32'h11,0,9,32'h99,     3,1,32'h40E);
    tbl[8]  = mk(1,1,4,32'h104,0,0,0,        0,5,32'h11,0,9,32'h99,     4,0,32'h41E);
    tbl[9]  = mk(1,1,5,32'h105,0,0,0,        0,5,32'h11,0,9,32'h99,     4,0,32'h41E);
    tbl[10] = mk(0,1,5,32'h105,0,0,0,        1,1,32'h101,0,9,32'h99,    3,1,32'h41E);
    tbl[11] = mk(0,1,5,32'h105,0,0,0,        1,2,32'h102,1,10,32'h20A,  3,1,32'h43C);
    tbl[12] = mk(0,0,0,0,0,0,0,              1,3,32'h103,0,10,32'h20A,  2,1,32'h38);
    tbl[13] = mk(0,0,0,0,0,0,0,              1,4,32'h104,0,10,32'h20A,  1,1,32'h30);
    tbl[14] = mk(0,0,0,0,0,0,0,              1,5,32'h105,0,10,32'h20A,  0,1,32'h20);
    tbl[15] = mk(0,0,0,0,0,0,0,              0,5,32'h105,0,10,32'h20A,  0,1,32'h0);

    // reset state
    do_reset();
    #1;
    chk("reset_state", {we_1, writeaddr_1, writedata_1, we_2, writeaddr_2, writedata_2, count, in_ready, pending},
        {1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 3'd0, 1'b1, 32'd0});

    // reset mid-burst with count=3 and a write on the ports
    for (int i = 1; i <= 4; i++) drive(1, 1, 5'(i), 32'h500 + i, 0, 0, 0);
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("pre_reset_burst", {count, we_1, writeaddr_1}, {3'd3, 1'b1, 5'd1});
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("reset_async", {count, we_1, we_2, in_ready, pending}, {3'd0, 1'b0, 1'b0, 1'b1, 32'd0});
    @(posedge clk);
    #1;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("reset_mid_burst", {count, we_1, we_2, in_ready, pending}, {3'd0, 1'b0, 1'b0, 1'b1, 32'd0});

    // table vectors from clean reset
    do_reset();
    for (int i = 0; i < 16; i++) begin
      drive(tbl[i].hold, tbl[i].v1, tbl[i].a1, tbl[i].d1, tbl[i].v2, tbl[i].a2, tbl[i].d2);
      chk($sformatf("vec%0d", i),
          {we_1, writeaddr_1, writedata_1, we_2, writeaddr_2, writedata_2, count, in_ready, pending},
          {tbl[i].e_we1, tbl[i].e_a1, tbl[i].e_d1, tbl[i].e_we2, tbl[i].e_a2, tbl[i].e_d2,
           tbl[i].e_cnt, tbl[i].e_rdy, tbl[i].e_pend});
    end

    // wrap: one pair parked, then sustained push+pop across pointer wrap
    for (int i = 0; i < 9; i++) begin
      wa1[i] = 5'(1 + (i % 15));
      wa2[i] = 5'(16 + (i % 15));
      wd1[i] = 32'hC000 + 32'(i);
      wd2[i] = 32'hD000 + 32'(i);
    end
    drive(1, 1, wa1[0], wd1[0], 1, wa2[0], wd2[0]);
    chk("wrap_park", {count, we_1, we_2}, {3'd1, 1'b0, 1'b0});
    for (int i = 1; i < 9; i++) begin
      drive(0, 1, wa1[i], wd1[i], 1, wa2[i], wd2[i]);
      chk($sformatf("wrap%0d", i),
          {count, in_ready, we_1, writeaddr_1, writedata_1, we_2, writeaddr_2, writedata_2},
          {3'd1, 1'b1, 1'b1, wa1[i-1], wd1[i-1], 1'b1, wa2[i-1], wd2[i-1]});
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("wrap_last", {count, we_1, writeaddr_1, writedata_1, we_2, writeaddr_2, writedata_2},
        {3'd0, 1'b1, wa1[8], wd1[8], 1'b1, wa2[8], wd2[8]});
    drive(0, 0, 0, 0, 0, 0, 0);
    chk("wrap_idle", {count, we_1, we_2, pending}, {3'd0, 1'b0, 1'b0, 32'd0});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
